// File: rtl/scaler_pkg.sv
// Shared constants and width helpers for the scaler bilinear datapath.
package scaler_pkg;
  localparam logic MODE_BILINEAR = 1'b0;
  localparam logic MODE_NEAREST  = 1'b1;
  localparam int   SB_EOL = 0;
  localparam int   SB_SOF = 1;

  function automatic int wgt_w(input int frac);
    return frac + 1;
  endfunction

  function automatic int acc_w(input int ch, input int frac);
    return ch + 2 * frac;
  endfunction
endpackage

// File: rtl/bilerp_lane.sv
// One channel of the bilinear datapath: horizontal blend, vertical blend, scale-down.
// SCALER_ROUND_EN selects round-half-up on the final shift instead of truncation.
module bilerp_lane
  import scaler_pkg::*;
#(
  parameter int CH_WIDTH   = 8,
  parameter int FRAC_WIDTH = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           adv,
  input  logic [CH_WIDTH-1:0]            p00,
  input  logic [CH_WIDTH-1:0]            p01,
  input  logic [CH_WIDTH-1:0]            p10,
  input  logic [CH_WIDTH-1:0]            p11,
  input  logic [wgt_w(FRAC_WIDTH)-1:0]   wx0,
  input  logic [wgt_w(FRAC_WIDTH)-1:0]   wx1,
  input  logic [wgt_w(FRAC_WIDTH)-1:0]   wy0,
  input  logic [wgt_w(FRAC_WIDTH)-1:0]   wy1,
  output logic [CH_WIDTH-1:0]            dout
);
  localparam int WW = wgt_w(FRAC_WIDTH);
  localparam int HW = CH_WIDTH + FRAC_WIDTH;
  localparam int AW = acc_w(CH_WIDTH, FRAC_WIDTH);

  logic [HW-1:0] top_q, bot_q;
  logic [WW-1:0] wy0_q, wy1_q;
  logic [AW-1:0] acc_q, acc_r;

`ifdef SCALER_ROUND_EN
  localparam logic [AW-1:0] RND = AW'(1) << (2 * FRAC_WIDTH - 1);
  assign acc_r = acc_q + RND;
`else
  assign acc_r = acc_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q <= '0;
      bot_q <= '0;
      wy0_q <= '0;
      wy1_q <= '0;
      acc_q <= '0;
      dout  <= '0;
    end else if (adv) begin
      top_q <= HW'(p00) * HW'(wx0) + HW'(p01) * HW'(wx1);
      bot_q <= HW'(p10) * HW'(wx0) + HW'(p11) * HW'(wx1);
      wy0_q <= wy0;
      wy1_q <= wy1;
      acc_q <= AW'(top_q) * AW'(wy0_q) + AW'(bot_q) * AW'(wy1_q);
      dout  <= CH_WIDTH'(acc_r >> (2 * FRAC_WIDTH));
    end
  end
endmodule

// File: rtl/bilinear_interp_pipe.sv
// 4-stage multi-channel bilinear/nearest interpolator with valid/ready and sideband.
// Build option SCALER_ROUND_EN enables round-half-up in the output stage.
module bilinear_interp_pipe
  import scaler_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int CH_WIDTH   = 8,
  parameter int FRAC_WIDTH = 6,
  parameter int SB_WIDTH   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         mode,
  input  logic [FRAC_WIDTH-1:0]        fx,
  input  logic [FRAC_WIDTH-1:0]        fy,
  input  logic [NUM_CH*CH_WIDTH-1:0]   p00,
  input  logic [NUM_CH*CH_WIDTH-1:0]   p01,
  input  logic [NUM_CH*CH_WIDTH-1:0]   p10,
  input  logic [NUM_CH*CH_WIDTH-1:0]   p11,
  input  logic [SB_WIDTH-1:0]          sb_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]   dout,
  output logic [SB_WIDTH-1:0]          sb_out
);
  localparam int WW     = wgt_w(FRAC_WIDTH);
  localparam int PW     = NUM_CH * CH_WIDTH;
  localparam int STAGES = 4;
  localparam logic [WW-1:0] ONE = WW'(1) << FRAC_WIDTH;

  typedef struct packed {
    logic [WW-1:0] wx0;
    logic [WW-1:0] wx1;
    logic [WW-1:0] wy0;
    logic [WW-1:0] wy1;
  } wgt_t;

  logic adv, take;
  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1][SB_WIDTH-1:0] sb_pipe;
  wgt_t                          w_d, w_q;
  logic [PW-1:0]                 p00_q, p01_q, p10_q, p11_q;

  // One shared stall: every stage moves only when the output slot is free or drained.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign take      = in_valid && adv;
  assign out_valid = vld_pipe[STAGES];
  assign sb_out    = sb_pipe[STAGES];

  always_comb begin
    w_d = '0;
    if (mode == MODE_NEAREST) begin
      w_d.wx1 = fx[FRAC_WIDTH-1] ? ONE : '0;
      w_d.wy1 = fy[FRAC_WIDTH-1] ? ONE : '0;
    end else begin
      w_d.wx1 = {1'b0, fx};
      w_d.wy1 = {1'b0, fy};
    end
    w_d.wx0 = ONE - w_d.wx1;
    w_d.wy0 = ONE - w_d.wy1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      sb_pipe  <= '0;
      w_q      <= '0;
      p00_q    <= '0;
      p01_q    <= '0;
      p10_q    <= '0;
      p11_q    <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], take};
      sb_pipe  <= {sb_pipe[STAGES-1:1], sb_in};
      w_q      <= w_d;
      p00_q    <= p00;
      p01_q    <= p01;
      p10_q    <= p10;
      p11_q    <= p11;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    bilerp_lane #(
      .CH_WIDTH  (CH_WIDTH),
      .FRAC_WIDTH(FRAC_WIDTH)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .p00 (p00_q[c*CH_WIDTH +: CH_WIDTH]),
      .p01 (p01_q[c*CH_WIDTH +: CH_WIDTH]),
      .p10 (p10_q[c*CH_WIDTH +: CH_WIDTH]),
      .p11 (p11_q[c*CH_WIDTH +: CH_WIDTH]),
      .wx0 (w_q.wx0),
      .wx1 (w_q.wx1),
      .wy0 (w_q.wy0),
      .wy1 (w_q.wy1),
      .dout(dout[c*CH_WIDTH +: CH_WIDTH])
    );
  end
endmodule
